// File: rtl/mult_iter_nxn.sv
// Iterative WIDTH x WIDTH multiplier: one CHUNK x CHUNK unsigned base multiplier is reused
// for each digit pair of the operand magnitudes, followed by a sign-fix cycle.
module mult_iter_nxn #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_signed,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_z,
    output logic               o_busy
);
    localparam int K  = WIDTH / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST_DIG = IW'(K - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 2) begin : g_param_check
        $error("mult_iter_nxn: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
    end

    typedef enum logic [1:0] {IDLE, MUL, SIGN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg;
    logic [IW-1:0]      di, dj;
    logic [PW-1:0]      acc;
    logic [CHUNK-1:0]   dig_a, dig_b;
    logic [2*CHUNK-1:0] pp;
    logic [PW-1:0]      pp_sh;

    // Two's complement magnitude; the most negative value maps onto 2^(WIDTH-1) unchanged.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        return (sgn && sv < 0) ? WIDTH'(-sv) : v;
    endfunction

    function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
        return ~v + PW'(1);
    endfunction

    assign dig_a = mag_a[int'(di)*CHUNK +: CHUNK];
    assign dig_b = mag_b[int'(dj)*CHUNK +: CHUNK];
    assign pp    = {{CHUNK{1'b0}}, dig_a} * {{CHUNK{1'b0}}, dig_b};
    assign pp_sh = PW'(pp) << (CHUNK * (int'(di) + int'(dj)));

    assign o_ready = (state == IDLE);
    assign o_busy  = (state == MUL) || (state == SIGN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_z     <= '0;
            acc     <= '0;
            di      <= '0;
            dj      <= '0;
            neg     <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mag_a <= magnitude(i_a, i_signed);
                        mag_b <= magnitude(i_b, i_signed);
                        neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        acc   <= '0;
                        di    <= '0;
                        dj    <= '0;
                        state <= MUL;
                    end
                end
                // di walks the a-digits fastest, dj the b-digits
                MUL: begin
                    acc <= acc + pp_sh;
                    if (di == LAST_DIG) begin
                        di <= '0;
                        if (dj == LAST_DIG) begin
                            dj    <= '0;
                            state <= SIGN;
                        end else begin
                            dj <= dj + IW'(1);
                        end
                    end else begin
                        di <= di + IW'(1);
                    end
                end
                SIGN: begin
                    o_z     <= neg ? negate(acc) : acc;
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_iter_nxn.sv
// Bench for mult_iter_nxn: directed vectors and corner sequences on a 16/8 instance,
// randomized products on 16/8 and 32/8 instances against a plain-arithmetic model.
module tb_mult_iter_nxn;
    logic clk = 1'b0;
    logic rst_n;

    logic        va16, s16, ir16, rdy16, ov16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] oz16;

    logic        va32, s32, ir32, rdy32, ov32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] oz32;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mult_iter_nxn #(.WIDTH(16), .CHUNK(8)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(va16), .o_ready(rdy16),
        .i_a(a16), .i_b(b16), .i_signed(s16), .o_valid(ov16),
        .i_ready(ir16), .o_z(oz16), .o_busy(busy16)
    );

    mult_iter_nxn #(.WIDTH(32), .CHUNK(8)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(va32), .o_ready(rdy32),
        .i_a(a32), .i_b(b32), .i_signed(s32), .o_valid(ov32),
        .i_ready(ir32), .o_z(oz32), .o_busy(busy32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] z;
    } vec_t;

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        return p;
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns product and edges from accept to o_valid.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [31:0] z, output int lat);
        int w;
        w = 0;
        while (!rdy16 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("ready16_before_accept", {63'd0, rdy16}, 64'd1);
        va16 = 1'b1; a16 = a; b16 = b; s16 = s;
        @(posedge clk); #1;
        va16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
        lat = 0;
        while (!ov16 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        z = oz16;
        ir16 = 1'b1;
        @(posedge clk); #1;
        ir16 = 1'b0;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] z, output int lat);
        int w;
        w = 0;
        while (!rdy32 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("ready32_before_accept", {63'd0, rdy32}, 64'd1);
        va32 = 1'b1; a32 = a; b32 = b; s32 = s;
        @(posedge clk); #1;
        va32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
        lat = 0;
        while (!ov32 && lat < 80) begin
            @(posedge clk); #1; lat++;
        end
        z = oz32;
        ir32 = 1'b1;
        @(posedge clk); #1;
        ir32 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [31:0] z;
        logic [63:0] z64;
        logic [31:0] held;
        logic [15:0] ra, rb;
        logic [31:0] ra32, rb32;
        logic        rs;
        int          lat;
        int          w;

        tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
        tbl[1] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
        tbl[2] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
        tbl[3] = '{16'h0000, 16'hFFFB, 1'b1, 32'h0000_0000};
        tbl[4] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB};
        tbl[5] = '{16'hFFFD, 16'h0007, 1'b0, 32'h0006_FFEB};
        tbl[6] = '{16'h0064, 16'h00C8, 1'b0, 32'h0000_4E20};
        tbl[7] = '{16'h0001, 16'hFFFF, 1'b1, 32'hFFFF_FFFF};

        rst_n = 1'b0;
        va16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; ir16 = 1'b0;
        va32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; ir32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", {63'd0, ov16}, 64'd0);
        check("reset_o_z", {32'd0, oz16}, 64'd0);
        check("reset_o_ready", {63'd0, rdy16}, 64'd1);
        check("reset_o_busy", {63'd0, busy16}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            op16(tbl[i].a, tbl[i].b, tbl[i].s, z, lat);
            check($sformatf("table%0d_z", i), {32'd0, z}, {32'd0, tbl[i].z});
            check($sformatf("table%0d_latency", i), 64'(lat), 64'd5);
        end

        // Backpressure: hold i_ready low in DONE while wiggling the request side
        va16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678; s16 = 1'b0;
        @(posedge clk); #1;
        va16 = 1'b0;
        w = 0;
        while (!ov16 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        held = oz16;
        check("bp_product", {32'd0, held}, {32'd0, ref16(16'h1234, 16'h5678, 1'b0)});
        for (int c = 0; c < 10; c++) begin
            va16 = 1'($urandom); a16 = 16'($urandom);
            @(posedge clk); #1;
            check("bp_o_z_stable", {32'd0, oz16}, {32'd0, held});
            check("bp_o_ready_low", {63'd0, rdy16}, 64'd0);
            check("bp_o_valid_high", {63'd0, ov16}, 64'd1);
        end
        va16 = 1'b0; ir16 = 1'b1;
        @(posedge clk); #1;
        ir16 = 1'b0;
        check("bp_o_valid_fall", {63'd0, ov16}, 64'd0);
        check("bp_o_ready_back", {63'd0, rdy16}, 64'd1);
        check("bp_no_second_accept", {63'd0, busy16}, 64'd0);
        check("bp_o_z_kept", {32'd0, oz16}, {32'd0, held});

        // Reset two cycles into MUL
        va16 = 1'b1; a16 = 16'h1234; b16 = 16'h00FF; s16 = 1'b0;
        @(posedge clk); #1;
        va16 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mul_o_valid", {63'd0, ov16}, 64'd0);
        check("rst_mul_o_z", {32'd0, oz16}, 64'd0);
        check("rst_mul_o_ready", {63'd0, rdy16}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while a result is waiting in DONE
        va16 = 1'b1; a16 = 16'h0102; b16 = 16'h0304; s16 = 1'b0;
        @(posedge clk); #1;
        va16 = 1'b0;
        w = 0;
        while (!ov16 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("rst_done_had_valid", {63'd0, ov16}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_done_o_valid", {63'd0, ov16}, 64'd0);
        check("rst_done_o_z", {32'd0, oz16}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op16(16'd100, 16'd200, 1'b0, z, lat);
        check("after_reset_z", {32'd0, z}, 64'h0000_4E20);
        check("after_reset_latency", 64'(lat), 64'd5);

        for (int i = 0; i < 40; i++) begin
            ra = pick16(); rb = pick16(); rs = 1'($urandom);
            op16(ra, rb, rs, z, lat);
            check($sformatf("rand16 %h*%h s=%0d", ra, rb, rs), {32'd0, z}, {32'd0, ref16(ra, rb, rs)});
            check("rand16_latency", 64'(lat), 64'd5);
        end

        for (int i = 0; i < 30; i++) begin
            ra32 = pick32(); rb32 = pick32(); rs = 1'($urandom);
            op32(ra32, rb32, rs, z64, lat);
            check($sformatf("rand32 %h*%h s=%0d", ra32, rb32, rs), z64, ref32(ra32, rb32, rs));
            check("rand32_latency", 64'(lat), 64'd17);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
